ps2_mouse_init_ctrl: RTL and testbench

- Sequences a PS/2 mouse through power-up initialisation: reset, BAT check, ID check, then enable data reporting.
- After initialisation, assembles stream-mode movement packets and presents them as single-cycle words.
- Sits between the user-interface buttons (reset and echo requests) and the existing PS/2 byte transmitter/receiver pair in Top.
- Owns all traffic on the shared PS/2 line; the transmitter has no other requester.

---
 rtl/ps2_mouse_init_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer and stream-mode packet assembler.
// Define PS2_MOUSE_INTELLIMOUSE_EN to add the wheel knock sequence and 4-byte packets.
module ps2_mouse_init_ctrl #(
   parameter int RESP_TIMEOUT = 1000000,
   parameter int BAT_TIMEOUT  = 25000000,
   parameter int MAX_RETRY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_reset,
   input  logic        cmd_echo,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic        tx_done,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_err,
   output logic [31:0] pkt_data,
   output logic        pkt_valid,
   output logic        ready,
   output logic        fail,
   output logic        echo_ok,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      SEND_RST    = 4'd0,
      WAIT_TX     = 4'd1,
      WAIT_ACK    = 4'd2,
      WAIT_BAT    = 4'd3,
      WAIT_ID     = 4'd4,
      SEND_EN     = 4'd5,
      WAIT_TX2    = 4'd6,
      WAIT_ACK2   = 4'd7,
      STREAM      = 4'd8,
      SEND_ECHO   = 4'd9,
      ECHO_TX     = 4'd10,
      ECHO_WAIT   = 4'd11,
      FAIL        = 4'd12,
      SEND_CFG    = 4'd13,
      WAIT_CFG_ID = 4'd14
   } state_t;

   localparam logic [31:0] RESP_LIM  = 32'(RESP_TIMEOUT - 1);
   localparam logic [31:0] BAT_LIM   = 32'(BAT_TIMEOUT - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

   state_t      state;
   state_t      resend_state;
   logic [31:0] tmo_cnt;
   logic [31:0] gap_cnt;
   logic [31:0] lim;
   logic [7:0]  retry_cnt;
   logic [1:0]  byte_cnt;
   logic [15:0] part;
   logic [7:0]  exp_byte;
   logic        is_wait;
   logic        is_tx_wait;
   logic        any_byte;
   logic        rx_ok;
   logic        tmo_fire;
   logic        advance;
   logic        resend;
   logic        fault;

`ifdef PS2_MOUSE_INTELLIMOUSE_EN
   logic [7:0]  part2;
   logic        wheel;
   logic        in_cfg;
   logic [2:0]  cfg_step;

   // Sample-rate knock 200/100/80 followed by Get Device ID.
   function automatic logic [7:0] cfg_byte(input logic [2:0] step);
      case (step)
         3'd1:    cfg_byte = 8'hC8;
         3'd3:    cfg_byte = 8'h64;
         3'd5:    cfg_byte = 8'h50;
         3'd6:    cfg_byte = 8'hF2;
         default: cfg_byte = 8'hF3;
      endcase
   endfunction
`endif

   assign state_dbg = state;

   // Classify the current wait state and decide whether it advances, resends or faults.
   always_comb begin
      is_wait      = 1'b1;
      is_tx_wait   = 1'b0;
      any_byte     = 1'b0;
      exp_byte     = 8'hFA;
      lim          = RESP_LIM;
      resend_state = SEND_RST;
      case (state)
         WAIT_TX, WAIT_TX2, ECHO_TX: is_tx_wait = 1'b1;
         WAIT_ACK:  exp_byte = 8'hFA;
         WAIT_BAT:  begin
            exp_byte = 8'hAA;
            lim      = BAT_LIM;
         end
         WAIT_ID:   exp_byte = 8'h00;
         WAIT_ACK2: begin
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
            resend_state = in_cfg ? SEND_CFG : SEND_EN;
`else
            resend_state = SEND_EN;
`endif
         end
         ECHO_WAIT: begin
            exp_byte     = 8'hEE;
            resend_state = SEND_ECHO;
         end
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
         WAIT_CFG_ID: any_byte = 1'b1;
`endif
         default:   is_wait = 1'b0;
      endcase
      rx_ok    = rx_valid && !rx_err;
      tmo_fire = is_wait && (tmo_cnt == lim);
      advance  = is_wait && (is_tx_wait ? tx_done
                                        : (rx_ok && (any_byte || (rx_data == exp_byte))));
      resend   = is_wait && !is_tx_wait && !advance && rx_ok && (rx_data == 8'hFE);
      fault    = is_wait && !advance && !resend &&
                 (tmo_fire || (!is_tx_wait && (rx_valid || rx_err)));
   end

   // Main sequencer: cmd_reset first, then wait-state faults/resends, then per-state progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= SEND_RST;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         pkt_data  <= 32'h0;
         pkt_valid <= 1'b0;
         ready     <= 1'b0;
         fail      <= 1'b0;
         echo_ok   <= 1'b0;
         tmo_cnt   <= 32'd0;
         gap_cnt   <= 32'd0;
         retry_cnt <= 8'd0;
         byte_cnt  <= 2'd0;
         part      <= 16'h0;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
         part2     <= 8'h00;
         wheel     <= 1'b0;
         in_cfg    <= 1'b0;
         cfg_step  <= 3'd0;
`endif
      end else begin
         tx_start  <= 1'b0;
         pkt_valid <= 1'b0;
         echo_ok   <= 1'b0;
         tmo_cnt   <= is_wait ? tmo_cnt + 32'd1 : 32'd0;
         if (advance || resend || fault) begin
            tmo_cnt <= 32'd0;
         end

         if (cmd_reset) begin
            state     <= SEND_RST;
            retry_cnt <= 8'd0;
            byte_cnt  <= 2'd0;
            gap_cnt   <= 32'd0;
            tmo_cnt   <= 32'd0;
            ready     <= 1'b0;
            fail      <= 1'b0;
         end else if (fault) begin
            if (retry_cnt >= RETRY_MAX) begin
               state <= FAIL;
               fail  <= 1'b1;
            end else begin
               retry_cnt <= retry_cnt + 8'd1;
               state     <= SEND_RST;
            end
         end else if (resend) begin
            state <= resend_state;
         end else begin
            case (state)
               SEND_RST: if (!tx_busy) begin
                  tx_data  <= 8'hFF;
                  tx_start <= 1'b1;
                  state    <= WAIT_TX;
               end
               WAIT_TX:  if (advance) state <= WAIT_ACK;
               WAIT_ACK: if (advance) state <= WAIT_BAT;
               WAIT_BAT: if (advance) state <= WAIT_ID;
               WAIT_ID:  if (advance) begin
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
                  wheel    <= 1'b0;
                  in_cfg   <= 1'b1;
                  cfg_step <= 3'd0;
                  state    <= SEND_CFG;
`else
                  state    <= SEND_EN;
`endif
               end
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
               SEND_CFG: if (!tx_busy) begin
                  tx_data  <= cfg_byte(cfg_step);
                  tx_start <= 1'b1;
                  state    <= WAIT_TX2;
               end
               WAIT_CFG_ID: if (advance) begin
                  wheel  <= (rx_data == 8'h03);
                  in_cfg <= 1'b0;
                  state  <= SEND_EN;
               end
`endif
               SEND_EN: if (!tx_busy) begin
                  tx_data  <= 8'hF4;
                  tx_start <= 1'b1;
                  state    <= WAIT_TX2;
               end
               WAIT_TX2: if (advance) state <= WAIT_ACK2;
               WAIT_ACK2: if (advance) begin
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
                  if (in_cfg) begin
                     if (cfg_step == 3'd6) begin
                        state <= WAIT_CFG_ID;
                     end else begin
                        cfg_step <= cfg_step + 3'd1;
                        state    <= SEND_CFG;
                     end
                  end else begin
                     retry_cnt <= 8'd0;
                     byte_cnt  <= 2'd0;
                     ready     <= 1'b1;
                     state     <= STREAM;
                  end
`else
                  retry_cnt <= 8'd0;
                  byte_cnt  <= 2'd0;
                  ready     <= 1'b1;
                  state     <= STREAM;
`endif
               end
               STREAM: begin
                  if (cmd_echo) begin
                     byte_cnt <= 2'd0;
                     gap_cnt  <= 32'd0;
                     ready    <= 1'b0;
                     state    <= SEND_ECHO;
                  end else if (rx_err) begin
                     byte_cnt <= 2'd0;
                     gap_cnt  <= 32'd0;
                  end else if (rx_valid) begin
                     gap_cnt <= 32'd0;
                     case (byte_cnt)
                        // Bit 3 of the header byte is always set; use it to regain alignment.
                        2'd0: if (rx_data[3]) begin
                           part[7:0] <= rx_data;
                           byte_cnt  <= 2'd1;
                        end
                        2'd1: begin
                           part[15:8] <= rx_data;
                           byte_cnt   <= 2'd2;
                        end
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
                        2'd2: if (wheel) begin
                           part2    <= rx_data;
                           byte_cnt <= 2'd3;
                        end else begin
                           pkt_data  <= {8'h00, rx_data, part};
                           pkt_valid <= 1'b1;
                           byte_cnt  <= 2'd0;
                        end
                        default: begin
                           pkt_data  <= {rx_data, part2, part};
                           pkt_valid <= 1'b1;
                           byte_cnt  <= 2'd0;
                        end
`else
                        default: begin
                           pkt_data  <= {8'h00, rx_data, part};
                           pkt_valid <= 1'b1;
                           byte_cnt  <= 2'd0;
                        end
`endif
                     endcase
                  end else if (byte_cnt != 2'd0) begin
                     if (gap_cnt == RESP_LIM) begin
                        byte_cnt <= 2'd0;
                        gap_cnt  <= 32'd0;
                     end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                     end
                  end
               end
               SEND_ECHO: if (!tx_busy) begin
                  tx_data  <= 8'hEE;
                  tx_start <= 1'b1;
                  state    <= ECHO_TX;
               end
               ECHO_TX: if (advance) state <= ECHO_WAIT;
               ECHO_WAIT: if (advance) begin
                  echo_ok   <= 1'b1;
                  retry_cnt <= 8'd0;
                  ready     <= 1'b1;
                  state     <= STREAM;
               end
               FAIL: state <= FAIL;
               default: state <= SEND_RST;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed self-checking bench for ps2_mouse_init_ctrl (default 3-byte build, short timeouts).
module tb_ps2_mouse_init_ctrl;

   localparam logic [3:0] ST_SEND_RST = 4'd0;
   localparam logic [3:0] ST_STREAM   = 4'd8;
   localparam logic [3:0] ST_FAIL     = 4'd12;

   logic        clk;
   logic        rst;
   logic        cmd_reset;
   logic        cmd_echo;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_done;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_err;
   logic [31:0] pkt_data;
   logic        pkt_valid;
   logic        ready;
   logic        fail;
   logic        echo_ok;
   logic [3:0]  state_dbg;

   logic        busyModel;
   logic        busyForce;
   int          totalChecks;
   int          passChecks;
   int          txCount;
   int          pktCount;
   int          echoCount;
   logic [31:0] lastPkt;
   int          txBase;

   assign tx_busy = busyModel | busyForce;

   ps2_mouse_init_ctrl #(
      .RESP_TIMEOUT(40),
      .BAT_TIMEOUT (80),
      .MAX_RETRY   (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_reset (cmd_reset),
      .cmd_echo  (cmd_echo),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .ready     (ready),
      .fail      (fail),
      .echo_ok   (echo_ok),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive monitor of the strobes, sampled on the falling edge.
   always @(negedge clk) begin
      if (tx_start) txCount <= txCount + 1;
      if (pkt_valid) begin
         pktCount <= pktCount + 1;
         lastPkt  <= pkt_data;
      end
      if (echo_ok) echoCount <= echoCount + 1;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passChecks++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Device sends one byte on the receive side.
   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseRxErr();
      rx_err = 1'b1;
      @(negedge clk);
      rx_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseReset();
      cmd_reset = 1'b1;
      @(negedge clk);
      cmd_reset = 1'b0;
   endtask

   task automatic pulseEcho();
      cmd_echo = 1'b1;
      @(negedge clk);
      cmd_echo = 1'b0;
   endtask

   // Wait for a transmit request, check the byte, then play the transmitter handshake.
   task automatic expectTx(input string tag, input logic [7:0] expByte);
      int   waited = 0;
      logic seen   = 1'b0;
      while (!seen && waited < 400) begin
         if (tx_start) seen = 1'b1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      checkOutput({tag, "_start"}, 32'(seen), 32'd1);
      if (seen) begin
         checkOutput(tag, 32'(tx_data), 32'(expByte));
         busyModel = 1'b1;
         repeat (3) @(negedge clk);
         checkOutput({tag, "_held"}, 32'(tx_data), 32'(expByte));
         tx_done = 1'b1;
         @(negedge clk);
         tx_done   = 1'b0;
         busyModel = 1'b0;
      end
   endtask

   task automatic finishInit(input string tag);
      applyStimulus(8'hFA);
      applyStimulus(8'hAA);
      applyStimulus(8'h00);
      expectTx({tag, "_en"}, 8'hF4);
      applyStimulus(8'hFA);
      checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
      checkOutput({tag, "_state"}, 32'(state_dbg), 32'(ST_STREAM));
      checkOutput({tag, "_fail"}, 32'(fail), 32'd0);
   endtask

   initial begin
      totalChecks = 0;
      passChecks  = 0;
      txCount     = 0;
      pktCount    = 0;
      echoCount   = 0;
      lastPkt     = 32'h0;
      rst         = 1'b0;
      cmd_reset   = 1'b0;
      cmd_echo    = 1'b0;
      tx_done     = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      rx_err      = 1'b0;
      busyModel   = 1'b0;
      busyForce   = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_txStart", 32'(tx_start), 32'd0);
      checkOutput("rst_ready", 32'(ready), 32'd0);
      checkOutput("rst_fail", 32'(fail), 32'd0);
      checkOutput("rst_pktValid", 32'(pkt_valid), 32'd0);
      checkOutput("rst_pktData", pkt_data, 32'h0);
      checkOutput("rst_echoOk", 32'(echo_ok), 32'd0);
      checkOutput("rst_state", 32'(state_dbg), 32'(ST_SEND_RST));
      rst = 1'b1;

      // Two resend requests, then a normal init.
      expectTx("resend1", 8'hFF);
      applyStimulus(8'hFE);
      expectTx("resend2", 8'hFF);
      applyStimulus(8'hFE);
      expectTx("resend3", 8'hFF);
      finishInit("init1");
      checkOutput("init1_txCount", 32'(txCount), 32'd4);

      // Stream packets.
      applyStimulus(8'h09);
      applyStimulus(8'h05);
      applyStimulus(8'hFB);
      checkOutput("pkt1_count", 32'(pktCount), 32'd1);
      checkOutput("pkt1_data", lastPkt, 32'h00FB0509);
      checkOutput("pkt1_hold", pkt_data, 32'h00FB0509);
      applyStimulus(8'h01);
      applyStimulus(8'h08);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      checkOutput("pkt2_count", 32'(pktCount), 32'd2);
      checkOutput("pkt2_data", lastPkt, 32'h00030208);
      applyStimulus(8'h09);
      repeat (60) @(negedge clk);
      applyStimulus(8'h0A);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      checkOutput("gap_count", 32'(pktCount), 32'd3);
      checkOutput("gap_data", lastPkt, 32'h0002010A);
      applyStimulus(8'h09);
      pulseRxErr();
      applyStimulus(8'h0C);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      checkOutput("rxerr_count", 32'(pktCount), 32'd4);
      checkOutput("rxerr_data", lastPkt, 32'h0022110C);

      // Echo: good reply, then a wrong reply.
      pulseEcho();
      checkOutput("echo_readyLow", 32'(ready), 32'd0);
      expectTx("echo1", 8'hEE);
      applyStimulus(8'hEE);
      checkOutput("echo1_ok", 32'(echoCount), 32'd1);
      checkOutput("echo1_ready", 32'(ready), 32'd1);
      pulseEcho();
      expectTx("echo2", 8'hEE);
      applyStimulus(8'h00);
      expectTx("echoBad_rst", 8'hFF);
      checkOutput("echo2_noOk", 32'(echoCount), 32'd1);
      finishInit("init2");

      // Silent device: four resets then FAIL.
      pulseReset();
      txBase = txCount;
      expectTx("silent1", 8'hFF);
      expectTx("silent2", 8'hFF);
      expectTx("silent3", 8'hFF);
      expectTx("silent4", 8'hFF);
      for (int i = 0; i < 200 && !fail; i++) @(negedge clk);
      checkOutput("silent_fail", 32'(fail), 32'd1);
      checkOutput("silent_state", 32'(state_dbg), 32'(ST_FAIL));
      repeat (100) @(negedge clk);
      checkOutput("silent_txCount", 32'(txCount - txBase), 32'd4);
      checkOutput("silent_ready", 32'(ready), 32'd0);
      pulseReset();
      checkOutput("failClr", 32'(fail), 32'd0);
      expectTx("afterFail", 8'hFF);
      finishInit("init3");

      // Reset and echo together while the transmitter is busy.
      busyForce = 1'b1;
      cmd_reset = 1'b1;
      cmd_echo  = 1'b1;
      @(negedge clk);
      cmd_reset = 1'b0;
      cmd_echo  = 1'b0;
      txBase    = txCount;
      repeat (10) @(negedge clk);
      checkOutput("busy_noStart", 32'(txCount - txBase), 32'd0);
      checkOutput("busy_state", 32'(state_dbg), 32'(ST_SEND_RST));
      busyForce = 1'b0;
      expectTx("busy_rst", 8'hFF);
      finishInit("init4");

      $display("[TB] %0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule
